l1_bus_ctrl: RTL and testbench
==============================

Name: l1_bus_ctrl

Overview:
Responder side of the L1 data-cache miss/write interface. Accepts level-held single-read, write-through, line-refill and dirty-line-writeback requests from the L1 and returns line beats, beat index, refill strobes and completion or error. It converts each request into single-beat transactions on a simple 64-bit memory-bus master port, with a per-beat timeout. It sits between the L1 and the BIU bus arbiter.

Parameters:
LINE_BEATS, 16, 64-bit beats per cache line (power of 2, 2..1024)
BEAT_SEL, $clog2(LINE_BEATS), beat index width
TIMEOUT, 255, cycles to wait for bus_ack per beat before declaring bus error (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
write_through_req  in  1  L1 requests a single write of wt_data at pa
read_req  in  1  L1 requests a single read at pa
read_line_req  in  1  L1 requests refill of the line containing pa
write_line_req  in  1  L1 requests writeback of the line containing pa
L1_size  in  4  one-hot access size: 0001=1B, 0010=2B, 0100=4B, 1000=8B
pa  in  64  physical address
wt_data  in  64  write data; during writeback, cache dout for the current addr_count, one cycle late
line_data  out  64  returned bus read data
addr_count  out  11  current beat index, zero-extended
line_write  out  1  one-cycle strobe: write line_data into the cache at addr_count
cache_entry_refill  out  1  one-cycle strobe: line refill complete, update the tag
trans_rdy  out  1  one-cycle pulse: request complete
bus_error  out  1  one-cycle pulse: request failed
bus_req  out  1  memory-bus request, held until ack or error
bus_we  out  1  1 = write
bus_addr  out  64  byte address
bus_size  out  4  one-hot size
bus_wdata  out  64  write data
bus_rdata  in  64  read data, valid with bus_ack
bus_ack  in  1  beat complete
bus_err  in  1  beat failed (takes priority over bus_ack)

Behaviour:
- All outputs are registered. On reset (rst==0 at a clk edge), every output is 0, the FSM goes to IDLE, and beat and timeout counters clear. Reset aborts any operation in flight; bus_req is low on the next cycle.
- States: IDLE, RD_SGL, WR_SGL, RD_LINE, WB_FETCH, WB_BEAT, DONE, ERR.
- IDLE arbitration, checked in this priority order:
  - write_line_req -> WB_FETCH
  - read_line_req -> RD_LINE
  - write_through_req -> WR_SGL
  - read_req -> RD_SGL
  - Beat counter cleared on entry.
- Line base address = pa with the low $clog2(LINE_BEATS*8) bits cleared. Line beat address = base + beat*8; line beats always use bus_size = 1000.
- RD_SGL / WR_SGL: one bus beat with bus_addr = pa and bus_size = L1_size. WR_SGL also drives bus_wdata = wt_data, captured on entry.
  - On ack: line_data = bus_rdata (read only), then go to DONE.
- RD_LINE, per beat:
  - Issue a read at the line beat address.
  - On ack: line_data = bus_rdata, addr_count = beat, line_write = 1 for one cycle.
  - If beat == LINE_BEATS-1, go to DONE and assert cache_entry_refill together with trans_rdy; otherwise increment beat and issue the next read on the following cycle.
- WB_FETCH: drive addr_count = beat and wait one cycle for the cache read latency, then go to WB_BEAT.
- WB_BEAT: capture wt_data into bus_wdata and issue a write at the line beat address.
  - On ack after the last beat, go to DONE; otherwise increment beat and return to WB_FETCH.
- DONE: trans_rdy = 1 for one cycle, then IDLE. Requests are re-sampled only from IDLE, so a request still held in the cycle after trans_rdy is treated as a new request. This is intentional: the L1 sync sequence relies on it, one line per request.
- Bus handshake:
  - bus_req rises the cycle after a beat is issued and falls in the cycle after ack or error.
  - At most one beat is outstanding.
  - bus_addr, bus_we, bus_size and bus_wdata are stable while bus_req is high.
- Errors: bus_err, or the timeout counter reaching TIMEOUT while bus_req is high, goes to ERR.
  - ERR pulses bus_error for one cycle (trans_rdy stays 0) and aborts the remaining beats, then goes to IDLE.
  - bus_err and bus_ack in the same cycle count as an error.
  - The timeout counter restarts at each beat issue.
- Request deasserted mid-operation: the current operation still completes; there is no cancellation.
- addr_count holds its last value between operations.

Decomposition:
- Shared package: FSM state encodings, the L1_size one-hot constants, and the LINE_BYTES/offset-width derivation.
- One sub-module, l1_bus_beat: issues a single bus beat and runs the timeout. Inputs are start, we, addr, size and wdata; outputs are done, err and rdata. The line-level FSM lives in l1_bus_ctrl.

Test Plan:
- read_req, pa=0x1003, L1_size=0001, memory returns 0xAB after a 3-cycle ack -> bus_addr=0x1003, bus_size=0001; line_data=0xAB; single trans_rdy pulse; line_write never asserts.
- read_line_req, pa=0x2048, LINE_BEATS=16 -> bus reads 0x2000..0x2078 in steps of 8; 16 line_write pulses with addr_count 0..15; cache_entry_refill and trans_rdy together exactly once after beat 15.
- write_line_req, model cache returns word=0x5A00+addr_count one cycle late -> 16 bus writes, bus_wdata=0x5A00..0x5A0F at matching addresses; one trans_rdy pulse.
- write_through_req and read_req both high in IDLE -> write issued first; read served only after trans_rdy, if still held.
- bus_err on beat 5 of a refill -> bus_error pulses once; no trans_rdy or cache_entry_refill; bus_req low afterwards; FSM back in IDLE.
- Edge cases:
  - No ack for TIMEOUT cycles -> bus_error.
  - rst=0 during WB_BEAT -> all outputs 0 next cycle; a new request after release is served normally.

Source files
------------

// File: rtl/l1_bus_ctrl_pkg.sv
// Shared definitions for the L1 bus controller.
//   state_e          : line-level FSM states
//   SIZE_*           : one-hot access sizes used on L1_size / bus_size
//   line_bytes()     : bytes in a cache line of the given beat count
//   line_offset_w()  : number of byte-offset bits inside a cache line
package l1_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SGL,
    ST_WR_SGL,
    ST_RD_LINE,
    ST_WB_FETCH,
    ST_WB_BEAT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [3:0] SIZE_1B = 4'b0001;
  localparam logic [3:0] SIZE_2B = 4'b0010;
  localparam logic [3:0] SIZE_4B = 4'b0100;
  localparam logic [3:0] SIZE_8B = 4'b1000;

  localparam int BEAT_BYTES = 8;

  function automatic int line_bytes(input int beats);
    return beats * BEAT_BYTES;
  endfunction

  function automatic int line_offset_w(input int beats);
    return $clog2(line_bytes(beats));
  endfunction

endpackage

// File: rtl/l1_bus_ctrl_beat.sv
// Single-beat memory-bus master with per-beat timeout.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   start               : issue a beat (only raised while bus_req is low)
//   we/addr/size/wdata  : beat attributes, captured on start
//   done                : beat acknowledged without error (combinational)
//   err                 : bus_err or timeout on the current beat (combinational)
//   rdata               : read data, valid with done
//   bus_*               : memory-bus master port
module l1_bus_beat #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [3:0]  size,
  input  logic [63:0] wdata,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  logic [7:0] timer_reg;

  // bus_err wins over a simultaneous ack; the timer also ends the beat.
  assign err   = bus_req && (bus_err || (timer_reg == 8'(TIMEOUT)));
  assign done  = bus_req && bus_ack && !err;
  assign rdata = bus_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_size  <= '0;
      bus_wdata <= '0;
      timer_reg <= '0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= we;
      bus_addr  <= addr;
      bus_size  <= size;
      bus_wdata <= wdata;
      timer_reg <= '0;
    end else if (bus_req) begin
      if (done || err) begin
        bus_req <= 1'b0;
      end else begin
        timer_reg <= timer_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/l1_bus_ctrl.sv
// L1 data-cache miss/write responder. Turns single reads, write-throughs,
// line refills and dirty-line writebacks into single 64-bit bus beats.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   *_req, L1_size, pa, wt_data  : level-held L1 requests and operands
//   line_data, addr_count        : returned data and current beat index
//   line_write                   : strobe to write line_data at addr_count
//   cache_entry_refill           : strobe, refill finished (with trans_rdy)
//   trans_rdy / bus_error        : completion / failure pulses
//   bus_*                        : memory-bus master port
module l1_bus_ctrl
  import l1_bus_ctrl_pkg::*;
#(
  parameter int LINE_BEATS = 16,
  parameter int BEAT_SEL   = $clog2(LINE_BEATS),
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic        write_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_refill,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int OFF_W = line_offset_w(LINE_BEATS);

  state_e              state_reg, state_next;
  logic [BEAT_SEL-1:0] beat_reg, beat_next;
  logic [63:0]         pa_reg, pa_next;
  logic [3:0]          size_reg, size_next;
  logic [63:0]         wt_reg, wt_next;
  logic [63:0]         line_data_next;
  logic [10:0]         addr_count_next;
  logic                line_write_next, refill_next;

  logic                start, beat_we, beat_done, beat_err;
  logic [63:0]         beat_addr, beat_wdata, beat_rdata, line_addr;
  logic [3:0]          beat_size;
  logic                last_beat;

  // Line base (offset bits cleared) plus beat*8.
  assign line_addr = {pa_reg[63:OFF_W], {OFF_W{1'b0}}}
                   + {{(61-BEAT_SEL){1'b0}}, beat_reg, 3'b000};
  assign last_beat = (beat_reg == BEAT_SEL'(LINE_BEATS-1));

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    pa_next         = pa_reg;
    size_next       = size_reg;
    wt_next         = wt_reg;
    line_data_next  = line_data;
    addr_count_next = addr_count;
    line_write_next = 1'b0;
    refill_next     = 1'b0;
    start           = 1'b0;
    beat_we         = 1'b0;
    beat_addr       = line_addr;
    beat_size       = SIZE_8B;
    beat_wdata      = '0;

    case (state_reg)
      ST_IDLE: begin
        // Operands are latched so a request dropped mid-operation still completes.
        beat_next = '0;
        pa_next   = pa;
        size_next = L1_size;
        wt_next   = wt_data;
        if (write_line_req) begin
          state_next      = ST_WB_FETCH;
          addr_count_next = '0;
        end else if (read_line_req) begin
          state_next = ST_RD_LINE;
        end else if (write_through_req) begin
          state_next = ST_WR_SGL;
        end else if (read_req) begin
          state_next = ST_RD_SGL;
        end
      end

      ST_RD_SGL, ST_WR_SGL: begin
        beat_addr  = pa_reg;
        beat_size  = size_reg;
        beat_we    = (state_reg == ST_WR_SGL);
        beat_wdata = wt_reg;
        start      = !bus_req;
        if (beat_err) begin
          state_next = ST_ERR;
        end else if (beat_done) begin
          if (state_reg == ST_RD_SGL) line_data_next = beat_rdata;
          state_next = ST_DONE;
        end
      end

      ST_RD_LINE: begin
        start = !bus_req;
        if (beat_err) begin
          state_next = ST_ERR;
        end else if (beat_done) begin
          line_data_next  = beat_rdata;
          addr_count_next = 11'(beat_reg);
          line_write_next = 1'b1;
          if (last_beat) begin
            state_next  = ST_DONE;
            refill_next = 1'b1;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end

      // addr_count already points at this beat; give the cache one cycle.
      ST_WB_FETCH: state_next = ST_WB_BEAT;

      ST_WB_BEAT: begin
        start      = !bus_req;
        beat_we    = 1'b1;
        beat_wdata = wt_data;
        if (beat_err) begin
          state_next = ST_ERR;
        end else if (beat_done) begin
          if (last_beat) begin
            state_next = ST_DONE;
          end else begin
            beat_next       = beat_reg + 1'b1;
            addr_count_next = 11'(beat_reg) + 11'd1;
            state_next      = ST_WB_FETCH;
          end
        end
      end

      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg          <= ST_IDLE;
      beat_reg           <= '0;
      pa_reg             <= '0;
      size_reg           <= '0;
      wt_reg             <= '0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      state_reg          <= state_next;
      beat_reg           <= beat_next;
      pa_reg             <= pa_next;
      size_reg           <= size_next;
      wt_reg             <= wt_next;
      line_data          <= line_data_next;
      addr_count         <= addr_count_next;
      line_write         <= line_write_next;
      cache_entry_refill <= refill_next;
      // Pulses are high exactly while the FSM sits in DONE / ERR.
      trans_rdy          <= (state_next == ST_DONE);
      bus_error          <= (state_next == ST_ERR);
    end
  end

  l1_bus_beat #(.TIMEOUT(TIMEOUT)) u_beat (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .we        (beat_we),
    .addr      (beat_addr),
    .size      (beat_size),
    .wdata     (beat_wdata),
    .done      (beat_done),
    .err       (beat_err),
    .rdata     (beat_rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_size  (bus_size),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

endmodule

// File: tb/tb_l1_bus_ctrl.sv
module tb_l1_bus_ctrl;
  import l1_bus_ctrl_pkg::*;

  localparam int LB = 16;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_through_req = 1'b0, read_req = 1'b0;
  logic        read_line_req = 1'b0, write_line_req = 1'b0;
  logic [3:0]  L1_size = 4'b0001;
  logic [63:0] pa = '0;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_refill, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [3:0]  bus_size;
  logic [63:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;

  // wt_data comes either from the task (write-through) or from the cache model.
  logic        cache_mode = 1'b0;
  logic [63:0] tb_wt = '0, cache_word = '0;
  assign wt_data = cache_mode ? cache_word : tb_wt;

  l1_bus_ctrl #(.LINE_BEATS(LB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .write_through_req(write_through_req), .read_req(read_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_refill(cache_entry_refill), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic we; logic [63:0] addr; logic [3:0] size; logic [63:0] wdata; } beat_t;
  typedef struct { logic [10:0] ac; logic [63:0] d; } lw_t;
  beat_t beat_q[$];
  lw_t   lw_q[$];

  // Responder / monitor state (written only by those processes).
  int tr_cnt = 0, be_cnt = 0, rf_cnt = 0, rf_tr_cnt = 0;
  int beat_no = 0, req_high_cnt = 0, hold_viol = 0, drop_viol = 0;
  bit in_beat = 1'b0, resp_prev = 1'b0;
  int lat = 0;
  beat_t cur;
  logic [10:0] last_ac = '0;

  // Responder controls (written only by the tasks).
  int min_lat = 0, max_lat = 3, err_beat = -1;
  bit hang = 1'b0, force_data = 1'b0;
  logic [63:0] force_val = '0;
  logic [63:0] mem_seed = 64'h0123_4567_89AB_CDEF;

  // Memory contents are a fixed function of the byte address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return force_data ? force_val : ((a * 64'h9E37_79B9_7F4A_7C15) ^ mem_seed);
  endfunction

  // Memory-bus responder: one log line per beat, randomized ack latency.
  always @(negedge clk) begin
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (resp_prev && bus_req !== 1'b0) drop_viol++;
    resp_prev = 1'b0;
    if (bus_req !== 1'b1) begin
      in_beat = 1'b0;
    end else begin
      req_high_cnt++;
      if (!in_beat) begin
        in_beat = 1'b1;
        cur.we = bus_we; cur.addr = bus_addr; cur.size = bus_size; cur.wdata = bus_wdata;
        beat_q.push_back(cur);
        lat = int'($urandom_range(max_lat, min_lat));
        $display("beat %0d: we=%0d addr=%h size=%b wdata=%h", beat_no, bus_we, bus_addr, bus_size, bus_wdata);
      end else if (bus_we !== cur.we || bus_addr !== cur.addr || bus_size !== cur.size || bus_wdata !== cur.wdata) begin
        hold_viol++;
      end
      if (lat > 0) begin
        lat--;
      end else if (!hang) begin
        if (beat_no == err_beat) bus_err = 1'b1;
        else begin
          bus_ack = 1'b1;
          bus_rdata = mem_word(bus_addr);
        end
        resp_prev = 1'b1;
        beat_no++;
      end
    end
  end

  // L1-side monitor and cache model (dout for addr_count, one cycle late).
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (line_write === 1'b1) lw_q.push_back('{addr_count, line_data});
      if (trans_rdy === 1'b1) tr_cnt++;
      if (bus_error === 1'b1) be_cnt++;
      if (cache_entry_refill === 1'b1) begin
        rf_cnt++;
        if (trans_rdy === 1'b1) rf_tr_cnt++;
      end
    end
    cache_word = 64'h5A00 + 64'(last_ac);
    last_ac = addr_count;
  end

  task automatic wait_end(input int limit, output bit got_tr, output bit got_err, output bit expired);
    got_tr = 1'b0; got_err = 1'b0; expired = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (trans_rdy === 1'b1 || bus_error === 1'b1) begin
        got_tr = trans_rdy; got_err = bus_error; expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
         bus_req, bus_we, bus_addr, bus_size, bus_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: line_data=%h addr_count=%0d bus_req=%b bus_addr=%h trans_rdy=%b required all 0",
               line_data, addr_count, bus_req, bus_addr, trans_rdy);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit tr, er, ex, wr;
    logic [63:0] p, w;
    logic [3:0] sz;
    int b0, l0, t0;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        p = 64'h1003; sz = 4'b0001; wr = 1'b0;
        force_data = 1'b1; force_val = 64'hAB; min_lat = 2; max_lat = 2;
      end else begin
        p = {$urandom, $urandom}; sz = 4'(1 << $urandom_range(3, 0)); wr = 1'($urandom_range(1, 0));
        force_data = 1'b0; min_lat = 0; max_lat = 4;
      end
      w = {$urandom, $urandom};
      b0 = beat_q.size(); l0 = lw_q.size(); t0 = tr_cnt;
      pa = p; L1_size = sz; tb_wt = w;
      if (wr) write_through_req = 1'b1; else read_req = 1'b1;
      @(negedge clk);
      tb_wt = ~w;  // data must have been captured when the request was taken
      wait_end(100, tr, er, ex);
      write_through_req = 1'b0; read_req = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ex || !tr || er) begin
        n_bad++; $display("FAIL single_done: trans_rdy=%b bus_error=%b expired=%b required trans_rdy", tr, er, ex);
      end
      n_cmp++;
      if (beat_q.size() - b0 != 1) begin
        n_bad++; $display("FAIL single_beats: got %0d beats required 1", beat_q.size() - b0);
      end else begin
        n_cmp++;
        if (beat_q[b0].addr !== p || beat_q[b0].size !== sz || beat_q[b0].we !== wr) begin
          n_bad++; $display("FAIL single_attr: addr=%h size=%b we=%b required addr=%h size=%b we=%b",
                            beat_q[b0].addr, beat_q[b0].size, beat_q[b0].we, p, sz, wr);
        end
        if (wr) begin
          n_cmp++;
          if (beat_q[b0].wdata !== w) begin
            n_bad++; $display("FAIL single_wdata: got %h required %h", beat_q[b0].wdata, w);
          end
        end
      end
      if (!wr) begin
        n_cmp++;
        if (line_data !== mem_word(p)) begin
          n_bad++; $display("FAIL single_rdata: line_data=%h required %h", line_data, mem_word(p));
        end
      end
      n_cmp++;
      if (tr_cnt - t0 != 1 || lw_q.size() != l0) begin
        n_bad++; $display("FAIL single_pulses: trans_rdy pulses=%0d line_write=%0d required 1 and 0",
                          tr_cnt - t0, lw_q.size() - l0);
      end
    end
    force_data = 1'b0;
  endtask

  task automatic test_refill();
    bit tr, er, ex;
    logic [63:0] p, base;
    int b0, l0, t0, r0, rt0;
    min_lat = 0; max_lat = 3;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 64'h2048 : {$urandom, $urandom};
      base = p & ~64'(LB * 8 - 1);
      b0 = beat_q.size(); l0 = lw_q.size(); t0 = tr_cnt; r0 = rf_cnt; rt0 = rf_tr_cnt;
      pa = p; read_line_req = 1'b1;
      wait_end(1000, tr, er, ex);
      read_line_req = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ex || !tr) begin
        n_bad++; $display("FAIL refill_done: trans_rdy=%b expired=%b required trans_rdy", tr, ex);
      end
      n_cmp++;
      if (beat_q.size() - b0 != LB) begin
        n_bad++; $display("FAIL refill_beats: got %0d required %0d", beat_q.size() - b0, LB);
      end else begin
        for (int i = 0; i < LB; i++) begin
          n_cmp++;
          if (beat_q[b0+i].we !== 1'b0 || beat_q[b0+i].addr !== base + 64'(8 * i) || beat_q[b0+i].size !== SIZE_8B) begin
            n_bad++; $display("FAIL refill_addr[%0d]: addr=%h size=%b we=%b required addr=%h size=1000 we=0",
                              i, beat_q[b0+i].addr, beat_q[b0+i].size, beat_q[b0+i].we, base + 64'(8 * i));
          end
        end
      end
      n_cmp++;
      if (lw_q.size() - l0 != LB) begin
        n_bad++; $display("FAIL refill_writes: got %0d line_write pulses required %0d", lw_q.size() - l0, LB);
      end else begin
        for (int i = 0; i < LB; i++) begin
          n_cmp++;
          if (lw_q[l0+i].ac !== 11'(i) || lw_q[l0+i].d !== mem_word(base + 64'(8 * i))) begin
            n_bad++; $display("FAIL refill_data[%0d]: addr_count=%0d data=%h required %0d %h",
                              i, lw_q[l0+i].ac, lw_q[l0+i].d, i, mem_word(base + 64'(8 * i)));
          end
        end
      end
      n_cmp++;
      if (rf_cnt - r0 != 1 || rf_tr_cnt - rt0 != 1 || tr_cnt - t0 != 1) begin
        n_bad++; $display("FAIL refill_strobes: refill=%0d refill_with_rdy=%0d trans_rdy=%0d required 1/1/1",
                          rf_cnt - r0, rf_tr_cnt - rt0, tr_cnt - t0);
      end
    end
  endtask

  task automatic test_writeback();
    bit tr, er, ex;
    logic [63:0] p, base;
    int b0, l0, t0;
    cache_mode = 1'b1; min_lat = 0; max_lat = 3;
    for (int it = 0; it < 2; it++) begin
      p = (it == 0) ? 64'h2048 : {$urandom, $urandom};
      base = p & ~64'(LB * 8 - 1);
      b0 = beat_q.size(); l0 = lw_q.size(); t0 = tr_cnt;
      pa = p; write_line_req = 1'b1;
      wait_end(1000, tr, er, ex);
      write_line_req = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ex || !tr) begin
        n_bad++; $display("FAIL wb_done: trans_rdy=%b expired=%b required trans_rdy", tr, ex);
      end
      n_cmp++;
      if (beat_q.size() - b0 != LB) begin
        n_bad++; $display("FAIL wb_beats: got %0d required %0d", beat_q.size() - b0, LB);
      end else begin
        for (int i = 0; i < LB; i++) begin
          n_cmp++;
          if (beat_q[b0+i].we !== 1'b1 || beat_q[b0+i].addr !== base + 64'(8 * i) ||
              beat_q[b0+i].size !== SIZE_8B || beat_q[b0+i].wdata !== 64'h5A00 + 64'(i)) begin
            n_bad++; $display("FAIL wb_beat[%0d]: addr=%h wdata=%h we=%b required addr=%h wdata=%h we=1",
                              i, beat_q[b0+i].addr, beat_q[b0+i].wdata, beat_q[b0+i].we,
                              base + 64'(8 * i), 64'h5A00 + 64'(i));
          end
        end
      end
      n_cmp++;
      if (tr_cnt - t0 != 1 || lw_q.size() != l0) begin
        n_bad++; $display("FAIL wb_pulses: trans_rdy=%0d line_write=%0d required 1 and 0", tr_cnt - t0, lw_q.size() - l0);
      end
    end
    cache_mode = 1'b0;
  endtask

  task automatic test_priority();
    bit tr, er, ex;
    int b0, t0;
    b0 = beat_q.size(); t0 = tr_cnt;
    pa = {$urandom, $urandom}; L1_size = SIZE_4B; tb_wt = {$urandom, $urandom};
    write_through_req = 1'b1; read_req = 1'b1;
    wait_end(100, tr, er, ex);
    write_through_req = 1'b0;
    n_cmp++;
    if (ex || beat_q.size() - b0 != 1 || beat_q[b0].we !== 1'b1) begin
      n_bad++; $display("FAIL prio_first: beats=%0d expired=%b required one write first", beat_q.size() - b0, ex);
    end
    wait_end(100, tr, er, ex);
    read_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ex || beat_q.size() - b0 != 2 || beat_q[b0+1].we !== 1'b0 || tr_cnt - t0 != 2) begin
      n_bad++; $display("FAIL prio_second: beats=%0d trans_rdy=%0d expired=%b required read second, 2 pulses",
                        beat_q.size() - b0, tr_cnt - t0, ex);
    end
  endtask

  task automatic test_bus_err();
    bit tr, er, ex;
    int l0, t0, e0, r0, b0;
    l0 = lw_q.size(); t0 = tr_cnt; e0 = be_cnt; r0 = rf_cnt; b0 = beat_q.size();
    err_beat = beat_no + 5;
    pa = {$urandom, $urandom}; read_line_req = 1'b1;
    wait_end(1000, tr, er, ex);
    read_line_req = 1'b0;
    err_beat = -1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ex || !er || tr) begin
      n_bad++; $display("FAIL err_end: bus_error=%b trans_rdy=%b expired=%b required bus_error only", er, tr, ex);
    end
    n_cmp++;
    if (be_cnt - e0 != 1 || tr_cnt != t0 || rf_cnt != r0) begin
      n_bad++; $display("FAIL err_pulses: bus_error=%0d trans_rdy=%0d refill=%0d required 1/0/0",
                        be_cnt - e0, tr_cnt - t0, rf_cnt - r0);
    end
    n_cmp++;
    if (lw_q.size() - l0 != 5 || beat_q.size() - b0 != 6 || bus_req !== 1'b0) begin
      n_bad++; $display("FAIL err_abort: line_writes=%0d beats=%0d bus_req=%b required 5/6/0",
                        lw_q.size() - l0, beat_q.size() - b0, bus_req);
    end
  endtask

  task automatic test_timeout();
    bit tr, er, ex;
    int e0, t0, h0;
    e0 = be_cnt; t0 = tr_cnt; h0 = req_high_cnt;
    hang = 1'b1;
    pa = {$urandom, $urandom}; L1_size = SIZE_8B; read_req = 1'b1;
    wait_end(TO + 50, tr, er, ex);
    read_req = 1'b0;
    hang = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ex || !er || be_cnt - e0 != 1 || tr_cnt != t0) begin
      n_bad++; $display("FAIL timeout_err: bus_error=%b pulses=%0d trans_rdy=%0d expired=%b required one bus_error",
                        er, be_cnt - e0, tr_cnt - t0, ex);
    end
    n_cmp++;
    if (req_high_cnt - h0 < TO || req_high_cnt - h0 > TO + 2) begin
      n_bad++; $display("FAIL timeout_len: bus_req high %0d cycles required %0d..%0d", req_high_cnt - h0, TO, TO + 2);
    end
  endtask

  task automatic test_reset_mid();
    bit tr, er, ex, seen;
    logic [63:0] p;
    int b0;
    cache_mode = 1'b1; hang = 1'b1; seen = 1'b0;
    pa = {$urandom, $urandom}; write_line_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL rstmid_start: bus_req=%b required 1 within 50 cycles", bus_req);
    end
    rst = 1'b0; write_line_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
         bus_req, bus_we, bus_addr, bus_size, bus_wdata} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: bus_req=%b bus_we=%b bus_addr=%h addr_count=%0d required all 0",
                        bus_req, bus_we, bus_addr, addr_count);
    end
    rst = 1'b1; hang = 1'b0; cache_mode = 1'b0;
    @(negedge clk);
    b0 = beat_q.size();
    p = {$urandom, $urandom}; pa = p; L1_size = SIZE_2B; read_req = 1'b1;
    wait_end(100, tr, er, ex);
    read_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ex || !tr || line_data !== mem_word(p) || beat_q.size() - b0 != 1) begin
      n_bad++; $display("FAIL rstmid_after: trans_rdy=%b line_data=%h beats=%0d required 1 %h 1",
                        tr, line_data, beat_q.size() - b0, mem_word(p));
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (hold_viol != 0) begin
      n_bad++; $display("FAIL bus_hold: attribute changes while bus_req high=%0d required 0", hold_viol);
    end
    n_cmp++;
    if (drop_viol != 0) begin
      n_bad++; $display("FAIL bus_drop: bus_req still high after ack/err=%0d required 0", drop_viol);
    end
  endtask

  initial begin
    mem_seed = {$urandom, $urandom};
    test_reset();
    test_single();
    test_refill();
    test_writeback();
    test_priority();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
